// File: rtl/score_digit_scheduler_pkg.sv
// Shared types and sizing helpers for the score digit scheduler.
package score_digit_scheduler_pkg;

  typedef enum logic [1:0] {IDLE, CONVERT, WAIT_VB} state_e;

  typedef logic [3:0] bcd_nibble_t;

  function automatic int unsigned pitch(input int unsigned digit_w, input int unsigned digit_gap);
    return digit_w + digit_gap;
  endfunction

  // ceil(w*log10(2) + 1); w*log10(2) is never an integer for w > 0, so the integer ceiling is exact
  function automatic int unsigned bcd_nibbles(input int unsigned score_w);
    return ((score_w * 30103 + 99999) / 100000) + 1;
  endfunction

  function automatic int unsigned bcd_width(input int unsigned score_w);
    return 4 * bcd_nibbles(score_w);
  endfunction

endpackage

// File: rtl/score_digit_scheduler_if.sv
// Score handshake plus pixel select bus between the scheduler and its host.
interface score_digit_scheduler_if #(
  parameter int unsigned SCORE_W = 14
);
  logic               score_valid_in;
  logic [SCORE_W-1:0] score_in;
  logic               score_ready_out;
  logic [10:0]        x_in;
  logic [9:0]         y_in;
  logic [10:0]        hcount_in;
  logic [9:0]         vcount_in;
  logic               sel_valid_out;
  logic [3:0]         number_out;
  logic [10:0]        digit_x_out;
  logic [9:0]         digit_y_out;
  logic [10:0]        hcount_out;
  logic [9:0]         vcount_out;
  logic               overflow_out;

  modport master (
    output score_valid_in, score_in, x_in, y_in, hcount_in, vcount_in,
    input  score_ready_out, sel_valid_out, number_out, digit_x_out, digit_y_out,
           hcount_out, vcount_out, overflow_out
  );

  modport slave (
    input  score_valid_in, score_in, x_in, y_in, hcount_in, vcount_in,
    output score_ready_out, sel_valid_out, number_out, digit_x_out, digit_y_out,
           hcount_out, vcount_out, overflow_out
  );
endinterface

// File: rtl/score_digit_scheduler_bcd.sv
// Sequential double-dabble: one shift per cycle, SCORE_W cycles from start.
module bin_to_bcd_seq
  import score_digit_scheduler_pkg::*;
#(
  parameter int unsigned SCORE_W = 14,
  localparam int unsigned BCD_W  = bcd_width(SCORE_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SCORE_W-1:0] bin,
  output logic               last,
  output logic [BCD_W-1:0]   bcd
);
  localparam int unsigned CW = $clog2(SCORE_W + 1);

  logic [SCORE_W-1:0] sh;
  logic [CW-1:0]      cnt;
  logic               busy;
  logic [BCD_W-1:0]   adj;

  always_comb begin
    adj = bcd;
    for (int unsigned k = 0; k < BCD_W / 4; k++) begin
      if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
    end
  end

  // high during the cycle whose edge performs the final shift
  assign last = busy && (cnt == CW'(SCORE_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      bcd  <= '0;
    end else if (start) begin
      sh   <= bin;
      cnt  <= '0;
      busy <= 1'b1;
      bcd  <= '0;
    end else if (busy) begin
      bcd <= {adj[BCD_W-2:0], sh[SCORE_W-1]};
      sh  <= sh << 1;
      cnt <= cnt + 1'b1;
      if (last) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/score_digit_scheduler.sv
// Score-to-digit scheduler sharing one numbers sprite between NUM_DIGITS slots.
// Optional LEADING_ZERO_BLANK_EN hides leading-zero slots (least significant slot always shown).
module score_digit_scheduler
  import score_digit_scheduler_pkg::*;
#(
  parameter int unsigned SCORE_W    = 14,
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIGIT_W    = 24,
  parameter int unsigned DIGIT_H    = 24,
  parameter int unsigned DIGIT_GAP  = 4,
  parameter int unsigned V_ACTIVE   = 720
) (
  input logic                      pixel_clk_in,
  input logic                      rst_in,
  score_digit_scheduler_if.slave   bus
);
  localparam int unsigned BCD_W = bcd_width(SCORE_W);
  localparam int unsigned NIB   = BCD_W / 4;
  localparam int unsigned PITCH = pitch(DIGIT_W, DIGIT_GAP);

  state_e             state, state_nxt;
  logic               start, load, conv_last, over_hi;
  logic [BCD_W-1:0]   bcd;
  bcd_nibble_t        disp [NUM_DIGITS];
  logic               ovf;

  bin_to_bcd_seq #(.SCORE_W(SCORE_W)) u_bcd (
    .clk   (pixel_clk_in),
    .rst   (rst_in),
    .start (start),
    .bin   (bus.score_in),
    .last  (conv_last),
    .bcd   (bcd)
  );

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: if (bus.score_valid_in) begin
        start     = 1'b1;
        state_nxt = CONVERT;
      end
      CONVERT: if (conv_last) state_nxt = WAIT_VB;
      WAIT_VB: if (bus.vcount_in >= 10'(V_ACTIVE)) begin
        load      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  assign bus.score_ready_out = (state == IDLE);
  assign bus.overflow_out    = ovf;

  always_comb begin
    over_hi = 1'b0;
    for (int unsigned k = NUM_DIGITS; k < NIB; k++) begin
      if (bcd[4*k +: 4] != 4'd0) over_hi = 1'b1;
    end
  end

  // slot 0 is the most significant digit
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) disp[i] <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++)
        disp[i] <= over_hi ? 4'd9 : bcd[4*(NUM_DIGITS-1-i) +: 4];
      ovf <= over_hi;
    end
  end

  logic [NUM_DIGITS-1:0] shown, hit;
  logic [10:0]           slot_x [NUM_DIGITS];
  logic                  v_in_row;

`ifdef LEADING_ZERO_BLANK_EN
  logic lz_seen;
  always_comb begin
    lz_seen = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      lz_seen  = lz_seen | (disp[i] != 4'd0) | (i == NUM_DIGITS - 1);
      shown[i] = lz_seen;
    end
  end
`else
  assign shown = '1;
`endif

  assign v_in_row = ({2'b00, bus.vcount_in} >= {2'b00, bus.y_in}) &&
                    ({2'b00, bus.vcount_in} <  {2'b00, bus.y_in} + 12'(DIGIT_H));

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_slot
    logic [11:0] left;
    assign left      = {1'b0, bus.x_in} + 12'(g * PITCH);
    assign hit[g]    = ({1'b0, bus.hcount_in} >= left) &&
                       ({1'b0, bus.hcount_in} <  left + 12'(DIGIT_W)) &&
                       v_in_row && shown[g];
    assign slot_x[g] = left[10:0];
  end

  logic        any;
  logic [3:0]  sel_num;
  logic [10:0] sel_x;

  always_comb begin
    any     = 1'b0;
    sel_num = '0;
    sel_x   = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (hit[i]) begin
        any     = 1'b1;
        sel_num = disp[i];
        sel_x   = slot_x[i];
      end
    end
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      bus.sel_valid_out <= 1'b0;
      bus.number_out    <= '0;
      bus.digit_x_out   <= '0;
      bus.digit_y_out   <= '0;
      bus.hcount_out    <= '0;
      bus.vcount_out    <= '0;
    end else begin
      bus.sel_valid_out <= any;
      bus.number_out    <= sel_num;
      bus.digit_x_out   <= sel_x;
      bus.digit_y_out   <= any ? bus.y_in : '0;
      bus.hcount_out    <= bus.hcount_in;
      bus.vcount_out    <= bus.vcount_in;
    end
  end
endmodule

// File: tb/tb_score_digit_scheduler.sv
// Randomized bench for score_digit_scheduler against a value-level display model.
`timescale 1ns/1ps
module tb_score_digit_scheduler;
  localparam int SW = 14, ND = 4, DW = 24, DH = 24, GAP = 4, PITCH = DW + GAP, VA = 720;
`ifdef LEADING_ZERO_BLANK_EN
  localparam int LZB = 1;
`else
  localparam int LZB = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  score_digit_scheduler_if #(.SCORE_W(SW)) bus();

  score_digit_scheduler #(
    .SCORE_W(SW), .NUM_DIGITS(ND), .DIGIT_W(DW), .DIGIT_H(DH),
    .DIGIT_GAP(GAP), .V_ACTIVE(VA)
  ) dut (
    .pixel_clk_in (clk),
    .rst_in       (rst),
    .bus          (bus.slave)
  );

  int n_vec = 0, n_err = 0;

  // model: displayed value (saturated), pending score and conversion countdown
  int m_disp, m_ovf, m_ready, m_conv, m_pend;
  int exp_sel, exp_num, exp_dx, exp_dy, exp_h, exp_v;

  function automatic int pow10(input int e);
    int r = 1;
    for (int k = 0; k < e; k++) r *= 10;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_disp = 0; m_ovf = 0; m_ready = 1; m_conv = 0; m_pend = 0;
    exp_sel = 0; exp_num = 0; exp_dx = 0; exp_dy = 0; exp_h = 0; exp_v = 0;
  endtask

  // expectations for the outputs after the coming rising edge
  task automatic predict();
    int h, v, x, y, left;
    h = int'(bus.hcount_in); v = int'(bus.vcount_in);
    x = int'(bus.x_in);      y = int'(bus.y_in);
    exp_sel = 0; exp_num = 0; exp_dx = 0; exp_dy = 0;
    for (int i = 0; i < ND; i++) begin
      left = x + i * PITCH;
      if (h >= left && h < left + DW && v >= y && v < y + DH &&
          (LZB == 0 || i == ND - 1 || m_disp >= pow10(ND - 1 - i))) begin
        exp_sel = 1;
        exp_num = (m_disp / pow10(ND - 1 - i)) % 10;
        exp_dx  = left;
        exp_dy  = y;
      end
    end
    exp_h = h; exp_v = v;
    if (m_ready != 0 && bus.score_valid_in === 1'b1) begin
      m_pend = int'(bus.score_in); m_ready = 0; m_conv = SW;
    end else if (m_ready == 0) begin
      if (m_conv > 0) m_conv--;
      else if (v >= VA) begin
        if (m_pend > pow10(ND) - 1) begin m_disp = pow10(ND) - 1; m_ovf = 1; end
        else begin m_disp = m_pend; m_ovf = 0; end
        m_ready = 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("ready",     bus.score_ready_out, m_ready);
    chk("sel_valid", bus.sel_valid_out,   exp_sel);
    chk("number",    bus.number_out,      exp_num);
    chk("digit_x",   bus.digit_x_out,     exp_dx);
    chk("digit_y",   bus.digit_y_out,     exp_dy);
    chk("hcount",    bus.hcount_out,      exp_h);
    chk("vcount",    bus.vcount_out,      exp_v);
    chk("overflow",  bus.overflow_out,    m_ovf);
  endtask

  task automatic step();
    predict();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic probe(input string nm, input int h, input int v, input int es, input int en, input int ex);
    bus.hcount_in = 11'(h);
    bus.vcount_in = 10'(v);
    step();
    chk({nm, "_sel"}, bus.sel_valid_out, es);
    chk({nm, "_num"}, bus.number_out, en);
    chk({nm, "_x"},   bus.digit_x_out, ex);
  endtask

  task automatic submit(input int s, output int low);
    bus.score_valid_in = 1'b1;
    bus.score_in       = SW'(s);
    bus.vcount_in      = 10'(730);
    step();
    bus.score_valid_in = 1'b0;
    low = 0;
    while (bus.score_ready_out !== 1'b1 && low < 200) begin
      low++;
      step();
    end
    chk("ready_return", bus.score_ready_out, 1);
  endtask

  initial begin
    int low, r, h, v, x, y;
    bus.score_valid_in = 1'b0; bus.score_in = '0;
    bus.x_in = 11'd100; bus.y_in = 10'd50;
    bus.hcount_in = '0; bus.vcount_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    compare_all();
    chk("reset_ready",  bus.score_ready_out, 1);
    chk("reset_number", bus.number_out, 0);

    submit(1234, low);
    chk("ready_low_cycles", low, SW + 1);
    chk("ovf_1234", bus.overflow_out, 0);
    probe("p_h100",  100, 50, 1, 1, 100);
    probe("p_h156",  156, 50, 1, 3, 156);
    for (int hh = 124; hh <= 127; hh++) probe("p_gap", hh, 50, 0, 0, 0);
    probe("p_v74",   100, 74, 0, 0, 0);
    probe("p_v73",   184, 73, 1, 4, 184);

    submit(12000, low);
    chk("ovf_12000", bus.overflow_out, 1);
    probe("p_sat", 128, 50, 1, 9, 128);

    // asynchronous reset while a conversion is in flight
    bus.score_valid_in = 1'b1; bus.score_in = SW'(5555); bus.vcount_in = 10'(730);
    step();
    bus.score_valid_in = 1'b0; bus.hcount_in = 11'd100; bus.vcount_in = 10'd50;
    repeat (4) step();
    #2 rst = 1'b1;
    #1;
    chk("rst_sel",   bus.sel_valid_out, 0);
    chk("rst_num",   bus.number_out, 0);
    chk("rst_hout",  bus.hcount_out, 0);
    chk("rst_ovf",   bus.overflow_out, 0);
    chk("rst_ready", bus.score_ready_out, 1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    compare_all();
    probe("p_rst0", 100, 50, 1 - LZB, 0, (LZB != 0) ? 0 : 100);
    bus.vcount_in = 10'(730);
    repeat (30) step();
    probe("p_rst3", 184, 50, 1, 0, 184);

    submit(42, low);
    chk("ovf_42", bus.overflow_out, 0);
    probe("p42_s2", 156, 50, 1, 4, 156);
    probe("p42_s3", 184, 60, 1, 2, 184);
    probe("p42_s0", 100, 50, 1 - LZB, 0, (LZB != 0) ? 0 : 100);

    // accepted mid-frame: display holds until blanking
    bus.score_valid_in = 1'b1; bus.score_in = SW'(5678);
    bus.hcount_in = 11'd156; bus.vcount_in = 10'd100;
    step();
    bus.score_valid_in = 1'b0; bus.vcount_in = 10'd50;
    repeat (40) step();
    chk("midframe_num",   bus.number_out, 4);
    chk("midframe_ready", bus.score_ready_out, 0);
    bus.vcount_in = 10'(VA);
    step();
    chk("vb_ready", bus.score_ready_out, 1);
    probe("p5678", 156, 50, 1, 7, 156);

    // valid held through conversion with a second value
    bus.score_valid_in = 1'b1; bus.score_in = SW'(300); bus.vcount_in = 10'(730);
    step();
    bus.score_in = SW'(8765);
    low = 0;
    while (bus.score_ready_out !== 1'b1 && low < 200) begin low++; step(); end
    chk("hold_first_done", bus.score_ready_out, 1);
    probe("p300", 128, 50, 1, 3, 128);
    bus.score_valid_in = 1'b0;
    chk("hold_second_taken", bus.score_ready_out, 0);
    bus.vcount_in = 10'(730);
    low = 0;
    while (bus.score_ready_out !== 1'b1 && low < 200) begin low++; step(); end
    chk("hold_second_done", bus.score_ready_out, 1);
    probe("p8765", 100, 50, 1, 8, 100);

    submit(7, low);
    probe("p7_s0", 100, 50, 1 - LZB, 0, (LZB != 0) ? 0 : 100);
    probe("p7_s2", 156, 50, 1 - LZB, 0, (LZB != 0) ? 0 : 156);
    probe("p7_s3", 184, 50, 1, 7, 184);
    submit(0, low);
    probe("p0_s3", 184, 50, 1, 0, 184);
    probe("p0_s2", 156, 50, 1 - LZB, 0, (LZB != 0) ? 0 : 156);

    for (int c = 0; c < 1500; c++) begin
      if (c % 150 == 0) begin
        case ($urandom % 4)
          0: begin bus.x_in = 11'd100;  bus.y_in = 10'd50;   end
          1: begin bus.x_in = 11'd2040; bus.y_in = 10'd1015; end
          2: begin bus.x_in = 11'd0;    bus.y_in = 10'd0;    end
          default: begin bus.x_in = 11'($urandom % 2048); bus.y_in = 10'($urandom % 1024); end
        endcase
      end
      if (bus.score_valid_in !== 1'b1 || m_ready != 0) begin
        case ($urandom % 6)
          0: bus.score_in = SW'(0);
          1: bus.score_in = SW'(9999);
          2: bus.score_in = SW'(10000);
          3: bus.score_in = SW'(16383);
          default: bus.score_in = SW'($urandom % 16384);
        endcase
      end
      bus.score_valid_in = (($urandom % 3) != 0);
      x = int'(bus.x_in); y = int'(bus.y_in);
      r = int'($urandom % 10);
      if (r < 5)      v = y - 2 + int'($urandom % (DH + 4));
      else if (r < 8) v = 700 + int'($urandom % 324);
      else            v = int'($urandom % 1024);
      if (v < 0) v = 0;
      if (v > 1023) v = 1023;
      h = x - 3 + int'($urandom % (ND * PITCH + 6));
      if (h < 0) h = 0;
      if (h > 2047) h = 2047;
      bus.hcount_in = 11'(h);
      bus.vcount_in = 10'(v);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
